// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage pipeline hazard controller:
//   - mem_state_e : data-memory wait FSM encoding (RUN / WAIT / ERR)
//   - REG_W, REG_ZERO : register-specifier width and the hard-wired $zero
//   - MEM_TIMEOUT_DEF : default number of WAIT cycles before giving up
//   - load_use_hit() : load-use match on the IF/ID source specifiers
// Optional feature macro used by the top: HAZ_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } mem_state_e;

   localparam int             REG_W           = 5;
   localparam logic [REG_W-1:0] REG_ZERO      = 5'd0;
   localparam int             MEM_TIMEOUT_DEF = 16;

   // A load writing $zero never produces a value worth waiting for, so it
   // cannot create a load-use hazard.
   function automatic logic load_use_hit(
      input logic             memread,
      input logic [REG_W-1:0] load_rt,
      input logic [REG_W-1:0] rs,
      input logic [REG_W-1:0] rt
   );
      return memread && (load_rt != REG_ZERO) &&
             ((load_rt == rs) || (load_rt == rt));
   endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// -----------------------------------------------------------------------------
// mem_wait_fsm
// Tracks a multi-cycle data-memory access and tells the top when the whole
// pipeline must be frozen. Gives up after MEM_TIMEOUT WAIT cycles without an
// acknowledge and parks in a sticky ERR state until reset.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   mem_access_i    : EX/MEM holds a load or store
//   mem_ack_i       : memory completes the access this cycle
//   mem_req_o       : request to data memory
//   freeze_o        : all pipeline registers must hold
//   err_o           : timeout error (sticky)
// -----------------------------------------------------------------------------
module mem_wait_fsm
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_access_i,
   input  logic mem_ack_i,
   output logic mem_req_o,
   output logic freeze_o,
   output logic err_o
);

   localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   mem_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_req_o = 1'b0;
      freeze_o  = 1'b0;
      err_o     = 1'b0;
      case (state_q)
         RUN: begin
            mem_req_o = mem_access_i;
            // A same-cycle ack is a zero-wait access: no freeze at all.
            if (mem_access_i && !mem_ack_i) begin
               freeze_o = 1'b1;
               state_d  = WAIT;
               cnt_d    = '0;
            end
         end
         WAIT: begin
            mem_req_o = 1'b1;
            if (mem_ack_i) begin
               // Release in the ack cycle so the result flows on at once.
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               freeze_o = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = ERR;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ERR: begin
            freeze_o = 1'b1;
            err_o    = 1'b1;
         end
         default: begin
            // Unreachable encoding: fail safe into the error state.
            freeze_o = 1'b1;
            state_d  = ERR;
         end
      endcase
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Drives the enable/flush lines of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// registers of a 5-stage MIPS pipeline. Priority, highest first:
//   memory error / memory freeze > branch flush > load-use stall.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   ifid_rs_i, ifid_rt_i             : source specifiers in IF/ID
//   idex_memread_i, idex_rt_i        : load in ID/EX and its destination
//   exmem_pcsrc_i                    : taken branch/jump resolved in EX/MEM
//   mem_access_i, mem_ack_i          : data-memory access and completion
//   mem_req_o                        : data-memory request
//   pc_en_o, ifid_en_o, idex_en_o, exmem_en_o : register load enables
//   ifid_flush_o, idex_flush_o, exmem_flush_o : register bubble inserts
//   memwb_bubble_o                   : MEM/WB takes RegWrite=0
//   err_o                            : sticky memory-timeout error
//   stall_cnt_o, flush_cnt_o         : saturating perf counters (macro only)
// Optional feature macro: HAZ_PERF_CNT_EN adds the perf counter ports.
// While rst is high every output is 0.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
`ifdef HAZ_PERF_CNT_EN
   parameter int CNT_W       = 32,
`endif
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] ifid_rs_i,
   input  logic [REG_W-1:0] ifid_rt_i,
   input  logic             idex_memread_i,
   input  logic [REG_W-1:0] idex_rt_i,
   input  logic             exmem_pcsrc_i,
   input  logic             mem_access_i,
   input  logic             mem_ack_i,
   output logic             mem_req_o,
   output logic             pc_en_o,
   output logic             ifid_en_o,
   output logic             ifid_flush_o,
   output logic             idex_en_o,
   output logic             idex_flush_o,
   output logic             exmem_en_o,
   output logic             exmem_flush_o,
   output logic             memwb_bubble_o,
`ifdef HAZ_PERF_CNT_EN
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
`endif
   output logic             err_o
);

   logic fsm_req;
   logic fsm_freeze;
   logic fsm_err;
   logic load_use;
   logic branch_flush;

   mem_wait_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait_fsm (
      .clk          (clk),
      .rst          (rst),
      .mem_access_i (mem_access_i),
      .mem_ack_i    (mem_ack_i),
      .mem_req_o    (fsm_req),
      .freeze_o     (fsm_freeze),
      .err_o        (fsm_err)
   );

   assign load_use     = load_use_hit(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i);
   assign branch_flush = !rst && !fsm_freeze && exmem_pcsrc_i;

   always_comb begin
      mem_req_o      = 1'b0;
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      ifid_flush_o   = 1'b0;
      idex_en_o      = 1'b0;
      idex_flush_o   = 1'b0;
      exmem_en_o     = 1'b0;
      exmem_flush_o  = 1'b0;
      memwb_bubble_o = 1'b0;
      err_o          = 1'b0;
      if (!rst) begin
         mem_req_o = fsm_req;
         err_o     = fsm_err;
         if (fsm_freeze) begin
            // Everything holds; only MEM/WB is forced to a non-writing bubble
            // so a stalled load is not written back repeatedly.
            memwb_bubble_o = 1'b1;
         end else begin
            pc_en_o    = 1'b1;
            ifid_en_o  = 1'b1;
            idex_en_o  = 1'b1;
            exmem_en_o = 1'b1;
            if (exmem_pcsrc_i) begin
               // Taken branch kills the three younger instructions; the
               // pending load-use (if any) is among them, so no stall.
               ifid_flush_o  = 1'b1;
               idex_flush_o  = 1'b1;
               exmem_flush_o = 1'b1;
            end else if (load_use) begin
               pc_en_o      = 1'b0;
               ifid_en_o    = 1'b0;
               idex_flush_o = 1'b1;
            end
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (branch_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   // Only the perf counter consumes the branch-flush strobe.
   logic unused_branch_flush;
   assign unused_branch_flush = branch_flush;
`endif

endmodule
